// File: rtl/prio_event_encoder.sv
// prio_event_encoder: registered priority encoder with sticky event capture.
// One-cycle request pulses are latched into a pending vector. The index of the
// winning enabled pending source is issued over a valid/ready handshake, and
// that source is cleared from the pending vector when its index is loaded.
// Optional feature macro: PRIO_ROUND_ROBIN_EN (rotating priority with a
// pointer register). When it is undefined the priority is fixed, MSB first.
module prio_event_encoder #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         req_in,
  input  logic [WIDTH-1:0]         mask_in,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(WIDTH)-1:0] out_idx,
  output logic [WIDTH-1:0]         pend_out,
  output logic                     overrun
);

  localparam int IDX_W = $clog2(WIDTH);

  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] sel_onehot;
  logic [WIDTH-1:0] pend_next;
  logic [IDX_W-1:0] sel_idx;
  logic             found;
  logic             load;
  logic             issue;

  // The output slot may be refilled when it is empty or being accepted.
  assign load  = ~out_valid | out_ready;
  assign cand  = pend & mask_in;
  assign issue = load & found;

`ifdef PRIO_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr;

  // Rotating search: start at ptr and move downward with wrap-around.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    sel_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      int               k;
      logic [IDX_W-1:0] kk;
      k  = (int'(ptr) >= i) ? int'(ptr) - i : int'(ptr) + WIDTH - i;
      kk = IDX_W'(k);
      if (!found && cand[kk]) begin
        sel_idx = kk;
        found   = 1'b1;
      end
    end
  end

  // Pointer moves just below the issued index; it changes only on an issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= IDX_W'(WIDTH - 1);
    end else if (flush) begin
      ptr <= IDX_W'(WIDTH - 1);
    end else if (issue) begin
      ptr <= (sel_idx == '0) ? IDX_W'(WIDTH - 1) : sel_idx - IDX_W'(1);
    end
  end
`else
  // Fixed priority: the highest set candidate index wins (later loop
  // iterations override earlier ones).
  always_comb begin
    sel_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (cand[i]) begin
        sel_idx = IDX_W'(i);
        found   = 1'b1;
      end
    end
  end
`endif

  // Clear only the bit actually issued; a same-cycle request re-sets it.
  always_comb begin
    sel_onehot = issue ? (WIDTH'(1) << sel_idx) : '0;
    pend_next  = (pend & ~sel_onehot) | req_in;
  end

  // Pending vector, output slot and overrun pulse.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      pend      <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      overrun   <= 1'b0;
    end else if (flush) begin
      pend      <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      pend    <= pend_next;
      overrun <= |(req_in & pend & ~sel_onehot);
      if (load) begin
        out_valid <= found;
        if (found) out_idx <= sel_idx;
      end
    end
  end

  assign pend_out = pend;

endmodule
